count_monitor: RTL

Receive-side checker for the divided-clock ripple counter on the DE1-SoC board. It samples the asynchronous, glitch-prone 4-bit counter output in the `CLOCK_50` domain and filters out ripple transients. Each settled value is checked against the expected increment sequence and shown on one HEX digit. A sticky error flag plus error and wrap counts go to spare LEDs/HEX for bring-up.

---
 rtl/count_monitor_pkg.sv | 31 +++
 rtl/hex_decoder.sv | 11 +
 rtl/count_monitor.sv | 124 ++++++++++++
 3 files changed

// File: rtl/count_monitor_pkg.sv
// rtl/count_monitor_pkg.sv - shared FSM encoding and seven-segment constants for count_monitor
package count_monitor_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segments, bit order gfedcba as wired on the DE1-SoC HEX digits.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex_decoder.sv
// rtl/hex_decoder.sv - combinational 4-bit to active-low seven-segment decoder
module hex_decoder
  import count_monitor_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_digit];

endmodule

// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - synchronizes, debounces and sequence-checks an external ripple counter
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic [6:0]       hex,
  output logic             seq_err,
  output logic [7:0]       err_count,
  output logic [7:0]       wraps
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] STAB_PRE = 8'(STABLE_CYCLES - 2);

  logic [WIDTH-1:0] r_s1, r_s2, r_cand, r_value;
  logic [7:0]       r_stab, r_err_count, r_wraps;
  logic             r_fresh, r_valid, r_seq_err;
  logic [6:0]       r_hex;
  state_t           r_state, w_state_next;

  logic             w_accept, w_load, w_err_inc, w_wrap_inc;
  logic [WIDTH-1:0] w_exp;
  logic [6:0]       w_seg;

  // r_fresh marks the single cycle after stab first reaches its ceiling,
  // so a long-held value produces exactly one accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_cand  <= '0;
      r_stab  <= '0;
      r_fresh <= 1'b0;
    end else begin
      r_s1 <= count_in;
      r_s2 <= r_s1;
      if (r_s2 != r_cand) begin
        r_cand  <= r_s2;
        r_stab  <= '0;
        r_fresh <= 1'b0;
      end else if (r_stab < STAB_MAX) begin
        r_stab  <= r_stab + 8'd1;
        r_fresh <= (r_stab == STAB_PRE);
      end else begin
        r_fresh <= 1'b0;
      end
    end
  end

  assign w_accept = r_fresh && ((r_state == ST_INIT) || (r_cand != r_value));
  assign w_exp    = r_value + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_err_inc    = 1'b0;
    w_wrap_inc   = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (w_accept) begin
          w_load       = 1'b1;
          w_state_next = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (r_cand == w_exp) w_wrap_inc = (r_cand == '0);
          else                 w_err_inc  = 1'b1;
        end
      end
      default: w_state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value     <= '0;
      r_valid     <= 1'b0;
      r_seq_err   <= 1'b0;
      r_err_count <= '0;
      r_wraps     <= '0;
    end else begin
      r_valid <= w_load;
      if (w_load) r_value <= r_cand;
      if (w_err_inc) begin
        r_seq_err <= 1'b1;
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end
      if (w_wrap_inc) r_wraps <= r_wraps + 8'd1;
    end
  end

  hex_decoder u_hex (
    .i_digit (r_value[3:0]),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk) begin
    if (reset)                     r_hex <= SEG_BLANK;
    else if (r_state == ST_INIT)   r_hex <= SEG_BLANK;
    else                           r_hex <= w_seg;
  end

  assign value     = r_value;
  assign valid     = r_valid;
  assign hex       = r_hex;
  assign seq_err   = r_seq_err;
  assign err_count = r_err_count;
  assign wraps     = r_wraps;

endmodule
